// File: rtl/rs_station.sv
// rs_station -- reservation station for ALU/branch ops.
//
// Takes ops from the dispatcher, holds them until both source operands are
// known (woken by either CDB), then issues the lowest-index ready op to the
// ALU, one per cycle. Load/store ops never come here.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   *_from_dsp          dispatch request (ena_from_dsp = valid)
//   *_rs_cdb, *_ls_cdb  ALU / LSB result broadcasts (tag 0 never matches)
//   flush               mispredict flush: drops every held op
//   full_to_if          free entries <= 2, stall fetch
//   *_to_alu            registered issue; ena_to_alu pulses one cycle per op
//
// Build option
//   RS_BYPASS_EN        when defined, an op that is ready at dispatch (after
//                       CDB forwarding) and finds no stored ready op is issued
//                       straight to the ALU at the dispatch edge without
//                       taking an entry.

// One storage slot. Holds the op, tracks operand tags and snoops both CDBs.
module rs_entry #(
  parameter int ROB_ID_W = 4,
  parameter int OPE_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                wr,
  input  logic                clr,
  input  logic [OPE_W-1:0]    d_op,
  input  logic [31:0]         d_v1,
  input  logic [31:0]         d_v2,
  input  logic [ROB_ID_W-1:0] d_q1,
  input  logic [ROB_ID_W-1:0] d_q2,
  input  logic [31:0]         d_pc,
  input  logic [31:0]         d_imm,
  input  logic [ROB_ID_W-1:0] d_rob,
  input  logic                rs_valid,
  input  logic [ROB_ID_W-1:0] rs_tag,
  input  logic [31:0]         rs_res,
  input  logic                ls_valid,
  input  logic [ROB_ID_W-1:0] ls_tag,
  input  logic [31:0]         ls_res,
  output logic                busy,
  output logic                ready,
  output logic [OPE_W-1:0]    op,
  output logic [31:0]         v1,
  output logic [31:0]         v2,
  output logic [31:0]         pc,
  output logic [31:0]         imm,
  output logic [ROB_ID_W-1:0] rob_id
);
  logic [ROB_ID_W-1:0] q1, q2;
  logic                rs_hit1, ls_hit1, rs_hit2, ls_hit2;

  // q != 0 guard makes a valid broadcast with tag 0 inert.
  assign rs_hit1 = rs_valid && (q1 != '0) && (rs_tag == q1);
  assign ls_hit1 = ls_valid && (q1 != '0) && (ls_tag == q1);
  assign rs_hit2 = rs_valid && (q2 != '0) && (rs_tag == q2);
  assign ls_hit2 = ls_valid && (q2 != '0) && (ls_tag == q2);

  assign ready = busy && (q1 == '0) && (q2 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      op     <= '0;
      v1     <= '0;
      v2     <= '0;
      q1     <= '0;
      q2     <= '0;
      pc     <= '0;
      imm    <= '0;
      rob_id <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy <= 1'b0;
      end else if (wr) begin
        // wr only targets a free slot, so it never collides with clr.
        busy   <= 1'b1;
        op     <= d_op;
        v1     <= d_v1;
        v2     <= d_v2;
        q1     <= d_q1;
        q2     <= d_q2;
        pc     <= d_pc;
        imm    <= d_imm;
        rob_id <= d_rob;
      end else begin
        if (clr) busy <= 1'b0;
        if (busy) begin
          if (rs_hit1) begin
            v1 <= rs_res;
            q1 <= '0;
          end else if (ls_hit1) begin
            v1 <= ls_res;
            q1 <= '0;
          end
          if (rs_hit2) begin
            v2 <= rs_res;
            q2 <= '0;
          end else if (ls_hit2) begin
            v2 <= ls_res;
            q2 <= '0;
          end
        end
      end
    end
  end
endmodule

module rs_station #(
  parameter int RS_SIZE  = 16,
  parameter int ROB_ID_W = 4,
  parameter int OPE_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ena_from_dsp,
  input  logic [OPE_W-1:0]    openum_from_dsp,
  input  logic [31:0]         V1_from_dsp,
  input  logic [31:0]         V2_from_dsp,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  input  logic [31:0]         pc_from_dsp,
  input  logic [31:0]         imm_from_dsp,
  input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
  input  logic                valid_rs_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_rs_cdb,
  input  logic [31:0]         result_rs_cdb,
  input  logic                valid_ls_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_ls_cdb,
  input  logic [31:0]         result_ls_cdb,
  input  logic                flush,
  output logic                full_to_if,
  output logic                ena_to_alu,
  output logic [OPE_W-1:0]    openum_to_alu,
  output logic [31:0]         V1_to_alu,
  output logic [31:0]         V2_to_alu,
  output logic [31:0]         pc_to_alu,
  output logic [31:0]         imm_to_alu,
  output logic [ROB_ID_W-1:0] rob_id_to_alu
);
  localparam int IDX_W   = $clog2(RS_SIZE);
  // Two slots of slack cover the ops already in fetch/decode when fetch stops.
  localparam int FULL_TH = RS_SIZE - 2;

  typedef struct packed {
    logic [OPE_W-1:0]    op;
    logic [31:0]         v1;
    logic [31:0]         v2;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [31:0]         pc;
    logic [31:0]         imm;
    logic [ROB_ID_W-1:0] rob;
  } rs_req_t;

  rs_req_t req;

  logic [RS_SIZE-1:0]               busy, ready, alloc_vec, issue_vec;
  logic [RS_SIZE-1:0][OPE_W-1:0]    e_op;
  logic [RS_SIZE-1:0][31:0]         e_v1, e_v2, e_pc, e_imm;
  logic [RS_SIZE-1:0][ROB_ID_W-1:0] e_rob;

  logic             any_free, any_ready, do_alloc, bypass, dsp_lost;
  logic [IDX_W-1:0] alloc_idx, issue_idx;
  logic [IDX_W:0]   busy_cnt;

  // Dispatch request with same-cycle CDB forwarding (ALU CDB first).
  always_comb begin
    req.op  = openum_from_dsp;
    req.v1  = V1_from_dsp;
    req.v2  = V2_from_dsp;
    req.q1  = Q1_from_dsp;
    req.q2  = Q2_from_dsp;
    req.pc  = pc_from_dsp;
    req.imm = imm_from_dsp;
    req.rob = rob_id_from_dsp;
    if (Q1_from_dsp != '0) begin
      if (valid_rs_cdb && rob_id_rs_cdb == Q1_from_dsp) begin
        req.v1 = result_rs_cdb;
        req.q1 = '0;
      end else if (valid_ls_cdb && rob_id_ls_cdb == Q1_from_dsp) begin
        req.v1 = result_ls_cdb;
        req.q1 = '0;
      end
    end
    if (Q2_from_dsp != '0) begin
      if (valid_rs_cdb && rob_id_rs_cdb == Q2_from_dsp) begin
        req.v2 = result_rs_cdb;
        req.q2 = '0;
      end else if (valid_ls_cdb && rob_id_ls_cdb == Q2_from_dsp) begin
        req.v2 = result_ls_cdb;
        req.q2 = '0;
      end
    end
  end

  // Lowest-index free slot, lowest-index ready slot and occupancy, all from
  // the registered busy/ready state so a slot freed by this cycle's issue
  // only becomes allocatable next cycle.
  always_comb begin
    any_free  = 1'b0;
    any_ready = 1'b0;
    alloc_idx = '0;
    issue_idx = '0;
    busy_cnt  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (ready[i]) begin
        any_ready = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_cnt = busy_cnt + {{IDX_W{1'b0}}, busy[i]};
    end
  end

`ifdef RS_BYPASS_EN
  // Stored ready ops keep priority over a ready-at-dispatch op.
  assign bypass = ena_from_dsp && (req.q1 == '0) && (req.q2 == '0) && !any_ready;
`else
  assign bypass = 1'b0;
`endif

  assign do_alloc   = ena_from_dsp && !bypass && any_free;
  assign dsp_lost   = ena_from_dsp && !bypass && !any_free;
  assign full_to_if = (int'(busy_cnt) >= FULL_TH);

  always_comb begin
    alloc_vec = '0;
    issue_vec = '0;
    if (do_alloc)  alloc_vec[alloc_idx] = 1'b1;
    if (any_ready) issue_vec[issue_idx] = 1'b1;
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    rs_entry #(
      .ROB_ID_W (ROB_ID_W),
      .OPE_W    (OPE_W)
    ) u_ent (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .flush    (flush),
      .wr       (alloc_vec[g]),
      .clr      (issue_vec[g]),
      .d_op     (req.op),
      .d_v1     (req.v1),
      .d_v2     (req.v2),
      .d_q1     (req.q1),
      .d_q2     (req.q2),
      .d_pc     (req.pc),
      .d_imm    (req.imm),
      .d_rob    (req.rob),
      .rs_valid (valid_rs_cdb),
      .rs_tag   (rob_id_rs_cdb),
      .rs_res   (result_rs_cdb),
      .ls_valid (valid_ls_cdb),
      .ls_tag   (rob_id_ls_cdb),
      .ls_res   (result_ls_cdb),
      .busy     (busy[g]),
      .ready    (ready[g]),
      .op       (e_op[g]),
      .v1       (e_v1[g]),
      .v2       (e_v2[g]),
      .pc       (e_pc[g]),
      .imm      (e_imm[g]),
      .rob_id   (e_rob[g])
    );
  end

  // Issue register. Data holds when nothing issues; only ena_to_alu drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_to_alu    <= 1'b0;
      openum_to_alu <= '0;
      V1_to_alu     <= '0;
      V2_to_alu     <= '0;
      pc_to_alu     <= '0;
      imm_to_alu    <= '0;
      rob_id_to_alu <= '0;
    end else if (rdy) begin
      if (flush) begin
        ena_to_alu    <= 1'b0;
        openum_to_alu <= '0;
        V1_to_alu     <= '0;
        V2_to_alu     <= '0;
        pc_to_alu     <= '0;
        imm_to_alu    <= '0;
        rob_id_to_alu <= '0;
      end else if (any_ready) begin
        ena_to_alu    <= 1'b1;
        openum_to_alu <= e_op[issue_idx];
        V1_to_alu     <= e_v1[issue_idx];
        V2_to_alu     <= e_v2[issue_idx];
        pc_to_alu     <= e_pc[issue_idx];
        imm_to_alu    <= e_imm[issue_idx];
        rob_id_to_alu <= e_rob[issue_idx];
      end else if (bypass) begin
        ena_to_alu    <= 1'b1;
        openum_to_alu <= req.op;
        V1_to_alu     <= req.v1;
        V2_to_alu     <= req.v2;
        pc_to_alu     <= req.pc;
        imm_to_alu    <= req.imm;
        rob_id_to_alu <= req.rob;
      end else begin
        ena_to_alu <= 1'b0;
      end
    end
  end

  // A dispatch into a full station loses the op; fetch gating should make
  // this impossible, so flag it loudly in simulation.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush) begin
      assert (!dsp_lost) else $error("rs_station: dispatch dropped, no free entry");
    end
  end
endmodule
